// File: rtl/mc_pkg.sv
// Shared types for the multicycle controller: state encoding, opcodes,
// datapath select encodings and the bundled control-strobe struct.
package mc_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        REX    = 4'd7,
        RWB    = 4'd8,
        IEX    = 4'd9,
        IWB    = 4'd10,
        BEQ    = 4'd11,
        JMP    = 4'd12,
        TRAP   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LI    = 6'b100111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // Final state of every legal instruction; leaving it retires the instruction.
    function automatic logic is_retire_state(input state_t s);
        return (s == MEMWB) || (s == MEMWR) || (s == RWB) ||
               (s == IWB)   || (s == BEQ)   || (s == JMP);
    endfunction

    function automatic logic is_mem_state(input state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Moore output decode: control strobes and selects from the current state.
// fetch_go gates the FETCH-cycle PC/IR writes while memory has not completed.
module mc_out_decode
    import mc_pkg::*;
(
    input  state_t state,
    input  logic   fetch_go,
    output ctrl_t  ctrl,
    output logic   illegal
);

    always_comb begin
        ctrl    = '0;
        illegal = 1'b0;
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = fetch_go;
                ctrl.pc_write  = fetch_go;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_BRANCH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            REX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            IEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            IWB: begin
                ctrl.reg_write = 1'b1;
            end
            // Branch target was computed in DECODE; the datapath qualifies with zero.
            BEQ: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            JMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            TRAP: begin
                illegal = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style controller: next-state logic and retired counter.
// Define MEM_HANDSHAKE_EN to stall FETCH/MEMRD/MEMWR until mem_ready=1.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state_o,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    // state  | meaning
    // IDLE   | post-reset, one cycle    FETCH  | read instr, PC+4
    // DECODE | opcode dispatch          MEMADR | lw/sw address
    // MEMRD  | load read                MEMWB  | load writeback
    // MEMWR  | store write              REX    | R-type execute
    // RWB    | R-type writeback         IEX    | immediate execute
    // IWB    | immediate writeback      BEQ    | branch compare
    // JMP    | jump                     TRAP   | illegal opcode, absorbing

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  retired_q;
    logic              advance;
    logic              fetch_go;
    logic              retire_now;
    ctrl_t             ctrl;

`ifdef MEM_HANDSHAKE_EN
    assign advance  = mem_ready || !is_mem_state(state_q);
    assign fetch_go = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign advance  = 1'b1;
    assign fetch_go = 1'b1;
`endif

    // zero only qualifies the PC write in the datapath; the sequence ignores it.
    logic unused_zero;
    assign unused_zero = zero;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   state_d = FETCH;
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:      state_d = REX;
                    OP_ADDI, OP_LI: state_d = IEX;
                    OP_LW, OP_SW:  state_d = MEMADR;
                    OP_BEQ:        state_d = BEQ;
                    OP_J:          state_d = JMP;
                    default:       state_d = TRAP;
                endcase
            end
            MEMADR: state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  state_d = MEMWB;
            REX:    state_d = RWB;
            IEX:    state_d = IWB;
            MEMWB, MEMWR, RWB, IWB, BEQ, JMP: state_d = FETCH;
            TRAP:   state_d = TRAP;
            default: state_d = TRAP;
        endcase
        if (!advance) state_d = state_q;
    end

    assign retire_now = advance && is_retire_state(state_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_q + CNT_W'(retire_now);
        end
    end

    mc_out_decode u_out_decode (
        .state    (state_q),
        .fetch_go (fetch_go),
        .ctrl     (ctrl),
        .illegal  (illegal)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign state_o     = state_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver pushes per-cycle expectations
// from an instruction-level model; a negedge monitor pops and compares.
module tb_multicycle_ctrl;
    import mc_pkg::*;

    localparam int CNT_W = 32;

`ifdef MEM_HANDSHAKE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic             MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0]       ALUSrcB, ALUOp, PCSource;
    logic [3:0]       state_o;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .state_o(state_o), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        state_t           st;
        logic [15:0]      ctrl;
        logic             ill;
        logic [CNT_W-1:0] ret;
    } exp_t;

    exp_t             exp_q[$];
    state_t           plan[$];
    int               vectors = 0;
    int               miscompares = 0;
    logic [CNT_W-1:0] m_retired;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource}
    function automatic logic [15:0] ref_ctrl(input state_t s, input bit stalled);
        logic [9:0] strobes;
        logic [5:0] sel;
        strobes = 10'b0;
        sel     = 6'b0;
        case (s)
            FETCH:  begin strobes = stalled ? 10'b0001000000 : 10'b1001010000; sel = 6'b01_00_00; end
            DECODE: sel = 6'b11_00_00;
            MEMADR: begin strobes = 10'b0000000001; sel = 6'b10_00_00; end
            MEMRD:  strobes = 10'b0011000000;
            MEMWB:  strobes = 10'b0000001010;
            MEMWR:  strobes = 10'b0010100000;
            REX:    begin strobes = 10'b0000000001; sel = 6'b00_10_00; end
            RWB:    strobes = 10'b0000000110;
            IEX:    begin strobes = 10'b0000000001; sel = 6'b10_00_00; end
            IWB:    strobes = 10'b0000000010;
            BEQ:    begin strobes = 10'b0100000001; sel = 6'b00_01_01; end
            JMP:    begin strobes = 10'b1000000000; sel = 6'b00_00_10; end
            default: ;
        endcase
        return {strobes, sel};
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op == OP_RTYPE || op == OP_ADDI || op == OP_LI || op == OP_LW ||
               op == OP_SW || op == OP_BEQ || op == OP_J;
    endfunction

    // Instruction-level sequence of states starting at FETCH.
    function automatic void make_plan(input logic [5:0] op);
        plan = {};
        plan.push_back(FETCH);
        plan.push_back(DECODE);
        if (op == OP_RTYPE)                   begin plan.push_back(REX); plan.push_back(RWB); end
        else if (op == OP_ADDI || op == OP_LI) begin plan.push_back(IEX); plan.push_back(IWB); end
        else if (op == OP_LW) begin plan.push_back(MEMADR); plan.push_back(MEMRD); plan.push_back(MEMWB); end
        else if (op == OP_SW) begin plan.push_back(MEMADR); plan.push_back(MEMWR); end
        else if (op == OP_BEQ) plan.push_back(BEQ);
        else if (op == OP_J)   plan.push_back(JMP);
        else for (int k = 0; k < 20; k++) plan.push_back(TRAP);
    endfunction

    task automatic push_exp(input state_t s, input bit stalled);
        exp_t e;
        e.st   = s;
        e.ctrl = ref_ctrl(s, stalled);
        e.ill  = (s == TRAP);
        e.ret  = m_retired;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit stalled);
        mem_ready = HS ? !stalled : 1'($urandom);
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; reset lands mid-cycle and is checked before the next edge.
    task automatic do_reset();
        #2;
        rst_n     = 1'b0;
        m_retired = '0;
        push_exp(IDLE, 1'b0);
        @(posedge clk);
        #1;
        push_exp(IDLE, 1'b0);
        rst_n = 1'b1;
        mem_ready = 1'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic z, input int fstall,
                             input int mstall, input bit preload);
        int reps;
        opcode = op;
        zero   = z;
        make_plan(op);
        for (int i = 0; i < plan.size(); i++) begin
            reps = 1;
            if (HS && plan[i] == FETCH) reps += fstall;
            if (HS && (plan[i] == MEMRD || plan[i] == MEMWR)) reps += mstall;
            for (int r = 0; r < reps; r++) begin
                if (preload && i == 0 && r == 0) begin
                    force dut.retired_q = '1;
                    m_retired = '1;
                end
                push_exp(plan[i], r < reps - 1);
                step(r < reps - 1);
                if (preload && i == 0 && r == 0) release dut.retired_q;
            end
        end
        if (is_legal(op)) m_retired = m_retired + CNT_W'(1);
    endtask

    task automatic sw_reset_mid();
        opcode = OP_SW;
        zero   = 1'b0;
        push_exp(FETCH, 1'b0);  step(1'b0);
        push_exp(DECODE, 1'b0); step(1'b0);
        push_exp(MEMADR, 1'b0); step(1'b0);
        do_reset();
    endtask

    function automatic logic [5:0] pick_legal(input int k);
        case (k)
            0: return OP_RTYPE;
            1: return OP_ADDI;
            2: return OP_LI;
            3: return OP_LW;
            4: return OP_SW;
            5: return OP_BEQ;
            default: return OP_J;
        endcase
    endfunction

    // Monitor
    initial begin
        exp_t        e;
        logic [15:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                       RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};
                vectors++;
                if (state_o !== 4'(e.st)) begin
                    miscompares++;
                    $display("FAIL state @%0t: got %0d want %0d (%s)", $time, state_o, e.st, e.st.name());
                end
                vectors++;
                if (act !== e.ctrl) begin
                    miscompares++;
                    $display("FAIL ctrl @%0t in %s: got %b want %b", $time, e.st.name(), act, e.ctrl);
                end
                vectors++;
                if (illegal !== e.ill) begin
                    miscompares++;
                    $display("FAIL illegal @%0t: got %b want %b", $time, illegal, e.ill);
                end
                vectors++;
                if (retired !== e.ret) begin
                    miscompares++;
                    $display("FAIL retired @%0t: got %0h want %0h", $time, retired, e.ret);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Driver
    initial begin
        logic [5:0] op;
        int         k;
        rst_n     = 1'b0;
        opcode    = 6'd0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        m_retired = '0;
        @(posedge clk);
        #1;
        do_reset();

        run_instr(OP_RTYPE, 1'b0, 0, 0, 1'b0);
        run_instr(OP_LW,    1'b0, 0, 3, 1'b0);
        run_instr(OP_BEQ,   1'b1, 0, 0, 1'b0);
        run_instr(OP_BEQ,   1'b0, 0, 0, 1'b0);
        run_instr(OP_SW,    1'b1, 1, 2, 1'b0);
        run_instr(OP_ADDI,  1'b0, 0, 0, 1'b0);
        run_instr(OP_LI,    1'b1, 2, 0, 1'b0);
        run_instr(OP_J,     1'b0, 0, 0, 1'b1);
        run_instr(6'b111111, 1'b0, 0, 0, 1'b0);
        do_reset();
        run_instr(OP_RTYPE, 1'b1, 0, 0, 1'b0);
        sw_reset_mid();

        for (int n = 0; n < 60; n++) begin
            k = int'($urandom_range(0, 9));
            if (k == 9) begin
                op = 6'($urandom);
                if (is_legal(op)) op = 6'b111110;
            end else begin
                op = pick_legal(k);
            end
            run_instr(op, 1'($urandom), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)), 1'b0);
            if (!is_legal(op)) do_reset();
        end

        @(posedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, giving the width of the retired-instruction counter.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port opcode  in  6  instruction bits [31:26] taken from the instruction register.
REQ-005 SHALL have port zero  in  1  ALU zero flag.
REQ-006 SHALL have port mem_ready  in  1  memory completion handshake.
REQ-007 SHALL have outputs PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite and ALUSrcA, each out 1, as datapath strobes and mux selects.
REQ-008 SHALL have outputs ALUSrcB, ALUOp and PCSource, each out 2, as datapath mux and ALU selects.
REQ-009 SHALL have outputs state_o  out 4  current state, illegal  out 1  sticky trap flag, and retired  out CNT_W  count of completed instructions.

Function
REQ-010 SHALL implement a Moore FSM; every control output SHALL be decoded from the current state only.
REQ-011 SHALL have exactly these states: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, RWB, IEX, IWB, BEQ, JMP, TRAP.
REQ-012 Outputs not listed for a state SHALL be 0 in that state.
REQ-013 IDLE SHALL drive all outputs to 0 and SHALL go to FETCH after one cycle.
REQ-014 FETCH SHALL assert MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01, ALUOp=00 and PCSource=00, with IorD=0 and ALUSrcA=0.
REQ-015 DECODE SHALL set ALUSrcB=11 and ALUOp=00 to compute the branch target.
REQ-016 DECODE SHALL branch on opcode: 000000->REX; 001000 or 100111->IEX; 100011 or 101011->MEMADR; 000100->BEQ; 000010->JMP; any other value->TRAP.
REQ-017 MEMADR SHALL set ALUSrcA=1 and ALUSrcB=10, then go to MEMRD for lw or MEMWR for sw.
REQ-018 MEMRD SHALL set MemRead=1 and IorD=1, then go to MEMWB.
REQ-019 MEMWB SHALL set RegWrite=1, MemtoReg=1 and RegDst=0, then go to FETCH.
REQ-020 MEMWR SHALL set MemWrite=1 and IorD=1, then go to FETCH.
REQ-021 REX SHALL set ALUSrcA=1, ALUSrcB=00 and ALUOp=10, then go to RWB.
REQ-022 RWB SHALL set RegWrite=1 and RegDst=1, then go to FETCH.
REQ-023 IEX SHALL set ALUSrcA=1, ALUSrcB=10 and ALUOp=00, then go to IWB.
REQ-024 IWB SHALL set RegWrite=1 and RegDst=0, then go to FETCH.
REQ-025 BEQ SHALL set ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1 and PCSource=01, then go to FETCH; the datapath SHALL update the PC only when zero=1.
REQ-026 JMP SHALL set PCWrite=1 and PCSource=10, then go to FETCH.
REQ-027 TRAP SHALL be absorbing, keep all strobes at 0, and set illegal=1 until reset.
REQ-028 Latency from FETCH entry to the next FETCH entry SHALL be: lw 5 cycles; R-type, addi/li and sw 4 cycles; beq and j 3 cycles (no memory stalls).
REQ-029 retired SHALL increment by 1 on leaving MEMWB, MEMWR, RWB, IWB, BEQ or JMP.
REQ-030 retired SHALL wrap from all-ones to 0.
REQ-031 retired SHALL NOT increment on entry to TRAP.

Reset
REQ-032 Asserting rst_n=0 SHALL immediately force IDLE, all control outputs to 0, illegal=0 and retired=0, regardless of the current state, including mid-instruction and mid-stall.
REQ-033 On release of rst_n, the first FETCH SHALL occur in the second rising edge's cycle.

Configuration
REQ-034 With MEM_HANDSHAKE_EN defined, FETCH, MEMRD and MEMWR SHALL hold their state and outputs while mem_ready=0 and advance on the edge where mem_ready=1.
REQ-035 While a state is stalled, PCWrite and IRWrite in FETCH SHALL be gated to 0 until mem_ready=1.
REQ-036 While a state is stalled, retired SHALL NOT increment.
REQ-037 Without MEM_HANDSHAKE_EN, mem_ready SHALL be ignored and every state SHALL last exactly one cycle.

Structure
REQ-038 Package mc_pkg SHALL hold the state enum (4-bit encoding), the opcode constants, and the ALUOp, ALUSrcB and PCSource encodings.
REQ-039 Combinational output decoding SHALL be placed in sub-module mc_out_decode, taking the state and returning all control outputs.
REQ-040 Next-state logic and counters SHALL reside in multicycle_ctrl.

Verification
REQ-041 Reset, then run with opcode=000000 -> state sequence IDLE, FETCH, DECODE, REX, RWB, FETCH; RegWrite=1 and RegDst=1 only in RWB; retired=1.
REQ-042 opcode=100011 with MEM_HANDSHAKE_EN and mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles with MemRead=1 and IorD=1; MEMWB follows with MemtoReg=1; retired increments once.
REQ-043 opcode=000100 run twice, zero=1 then zero=0 -> BEQ shows PCWriteCond=1 and PCSource=01 both times; 3-cycle loop each time.
REQ-044 opcode=111111 -> TRAP after DECODE; illegal=1 held for 20 cycles; retired unchanged; rst_n pulse clears to IDLE.
REQ-045 rst_n asserted asynchronously mid-MEMWR -> outputs 0 before the next clock edge; retired=0.
REQ-046 Preload retired to all-ones via force, then complete one j instruction -> retired=0.
